fpu_norm_pipe: RTL and testbench

- Pipelined, parametrised normalisation stage for the FPU add/sub datapath. It sits after the mantissa adder and before rounding.
- Takes a raw adder result (carry bit, hidden-bit position, guard/round/sticky), a biased exponent and a sign. Produces a normalised mantissa with an adjusted exponent.
- Adds over the single-cycle combinational normaliser: exponent adjustment, subnormal clamping, exponent-overflow detection, sticky preservation on right shift, and a valid/ready handshake with backpressure.

---
 rtl/fpu_norm_pkg.sv | 26 ++
 rtl/fpu_lzc.sv | 25 ++
 rtl/fpu_norm_pipe.sv | 158 +++++++++++++++
 tb/tb_fpu_norm_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_norm_pkg.sv
// Shared types and constants for the FPU add/sub normalisation pipeline.
package fpu_norm_pkg;

    localparam int NORM_MANT_W = 28;
    localparam int NORM_EXP_W  = 8;

    // The hidden one sits one below the carry bit at the top of the mantissa.
    function automatic int hidden_idx(input int size_mant);
        return size_mant - 2;
    endfunction

    localparam int HIDDEN_IDX = hidden_idx(NORM_MANT_W);

    typedef struct packed {
        logic                   sign;
        logic [NORM_EXP_W-1:0]  exponent;
        logic [NORM_MANT_W-1:0] mantissa;
    } norm_beat_t;

    typedef struct packed {
        logic zero;
        logic underflow;
        logic exp_overflow;
    } norm_flags_t;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; counts from the MSB down and returns
// WIDTH when no bit is set.
module fpu_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_all_zero
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        o_count    = CNT_W'(WIDTH);
        o_all_zero = 1'b1;
        // Later iterations overwrite earlier ones, so the highest set bit wins.
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_count    = CNT_W'(WIDTH - 1 - i);
                o_all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fpu_norm_pipe.sv
// Two-stage normaliser after the mantissa adder: stage 1 captures the beat
// and its leading-zero count, stage 2 shifts, adjusts the exponent and flags.
module fpu_norm_pipe
    import fpu_norm_pkg::*;
#(
    parameter  int SIZE_MANT = NORM_MANT_W,
    parameter  int SIZE_EXP  = NORM_EXP_W,
    localparam int SIZE_LOPD = $clog2(SIZE_MANT)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_overflow,
    input  logic                 i_sign,
    input  logic [SIZE_EXP-1:0]  i_exponent,
    input  logic [SIZE_MANT-1:0] i_mantissa,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sign,
    output logic [SIZE_EXP-1:0]  o_exponent,
    output logic [SIZE_MANT-1:0] o_mantissa,
    output logic                 o_zero_flag,
    output logic                 o_underflow,
    output logic                 o_exp_overflow
);

    localparam int HID = hidden_idx(SIZE_MANT);

    typedef struct packed {
        logic                 sign;
        logic [SIZE_EXP-1:0]  exponent;
        logic [SIZE_MANT-1:0] mantissa;
    } beat_t;

    logic en;

    logic [SIZE_LOPD-1:0] lzc_count;
    logic                 lzc_all_zero;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_ovf_q,   s1_ovf_d;
    logic                 s1_zero_q,  s1_zero_d;
    logic [SIZE_LOPD-1:0] s1_lzc_q,   s1_lzc_d;
    beat_t                s1_beat_q,  s1_beat_d;

    logic                 s2_valid_q, s2_valid_d;
    beat_t                s2_beat_q,  s2_beat_d;
    norm_flags_t          s2_flags_q, s2_flags_d;

    beat_t                res_beat;
    norm_flags_t          res_flags;
    logic [SIZE_EXP:0]    exp_ext, exp_inc, lzc_ext;
    logic [SIZE_EXP-1:0]  sub_shift;

    // A single enable for both stages: the pipe moves only when the output slot frees.
    assign en      = ~s2_valid_q | i_ready;
    assign o_ready = en;

    fpu_lzc #(
        .WIDTH (SIZE_MANT - 1),
        .CNT_W (SIZE_LOPD)
    ) u_lzc (
        .i_data     (i_mantissa[HID:0]),
        .o_count    (lzc_count),
        .o_all_zero (lzc_all_zero)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_ovf_d   = s1_ovf_q;
        s1_zero_d  = s1_zero_q;
        s1_lzc_d   = s1_lzc_q;
        s1_beat_d  = s1_beat_q;
        if (en) begin
            s1_valid_d         = i_valid;
            s1_ovf_d           = i_overflow;
            s1_zero_d          = ~i_overflow & lzc_all_zero & ~i_mantissa[SIZE_MANT-1];
            s1_lzc_d           = lzc_count;
            s1_beat_d.sign     = i_sign;
            s1_beat_d.exponent = i_exponent;
            s1_beat_d.mantissa = i_mantissa;
        end
    end

    always_comb begin
        exp_ext   = {1'b0, s1_beat_q.exponent};
        exp_inc   = exp_ext + (SIZE_EXP + 1)'(1);
        lzc_ext   = (SIZE_EXP + 1)'(s1_lzc_q);
        sub_shift = (s1_beat_q.exponent == '0) ? '0 : s1_beat_q.exponent - SIZE_EXP'(1);
        res_beat      = '0;
        res_flags     = '0;
        res_beat.sign = s1_beat_q.sign;
        if (s1_zero_q) begin
            res_flags.zero = 1'b1;
        end else if (s1_ovf_q) begin
            if (exp_inc >= {1'b0, {SIZE_EXP{1'b1}}}) begin
                res_beat.exponent      = '1;
                res_flags.exp_overflow = 1'b1;
            end else begin
                // Keep the bit shifted out as sticky for rounding.
                res_beat.mantissa = {1'b0, s1_beat_q.mantissa[SIZE_MANT-1:1]}
                                  | SIZE_MANT'(s1_beat_q.mantissa[0]);
                res_beat.exponent = exp_inc[SIZE_EXP-1:0];
            end
        end else if (exp_ext > lzc_ext) begin
            res_beat.mantissa = s1_beat_q.mantissa << s1_lzc_q;
            res_beat.exponent = s1_beat_q.exponent - SIZE_EXP'(s1_lzc_q);
        end else begin
            res_beat.mantissa   = s1_beat_q.mantissa << sub_shift;
            res_flags.underflow = 1'b1;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_beat_d  = s2_beat_q;
        s2_flags_d = s2_flags_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            s2_beat_d  = res_beat;
            s2_flags_d = res_flags;
        end
    end

    // NOTE: datapath flops are reset too, so outputs read zero straight after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_ovf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_lzc_q   <= '0;
            s1_beat_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_beat_q  <= '0;
            s2_flags_q <= '0;
        end else begin
            // NOTE: non-blocking so both stages sample the pre-edge values.
            s1_valid_q <= s1_valid_d;
            s1_ovf_q   <= s1_ovf_d;
            s1_zero_q  <= s1_zero_d;
            s1_lzc_q   <= s1_lzc_d;
            s1_beat_q  <= s1_beat_d;
            s2_valid_q <= s2_valid_d;
            s2_beat_q  <= s2_beat_d;
            s2_flags_q <= s2_flags_d;
        end
    end

    assign o_valid        = s2_valid_q;
    assign o_sign         = s2_beat_q.sign;
    assign o_exponent     = s2_beat_q.exponent;
    assign o_mantissa     = s2_beat_q.mantissa;
    assign o_zero_flag    = s2_flags_q.zero;
    assign o_underflow    = s2_flags_q.underflow;
    assign o_exp_overflow = s2_flags_q.exp_overflow;

endmodule

// File: tb/tb_fpu_norm_pipe.sv
// Self-checking bench for fpu_norm_pipe: directed corner cases, backpressure,
// reset with beats in flight, then random traffic against a reference model.
module tb_fpu_norm_pipe;
    import fpu_norm_pkg::*;

    localparam int MW = 28;
    localparam int EW = 8;

    logic          i_clk, i_rst, i_valid, o_ready, i_overflow, i_sign;
    logic [EW-1:0] i_exponent;
    logic [MW-1:0] i_mantissa;
    logic          o_valid, i_ready, o_sign;
    logic [EW-1:0] o_exponent;
    logic [MW-1:0] o_mantissa;
    logic          o_zero_flag, o_underflow, o_exp_overflow;

    fpu_norm_pipe #(.SIZE_MANT(MW), .SIZE_EXP(EW)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_overflow     (i_overflow),
        .i_sign         (i_sign),
        .i_exponent     (i_exponent),
        .i_mantissa     (i_mantissa),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_sign         (o_sign),
        .o_exponent     (o_exponent),
        .o_mantissa     (o_mantissa),
        .o_zero_flag    (o_zero_flag),
        .o_underflow    (o_underflow),
        .o_exp_overflow (o_exp_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        norm_beat_t  beat;
        norm_flags_t flags;
    } exp_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Reference: normalisation rules computed with plain integer arithmetic.
    function automatic exp_t ref_norm(input bit ovf, input bit sign, input int e, input longint m);
        exp_t   r;
        longint mask;
        int     lz;
        int     sh;
        mask = (longint'(1) << MW) - 1;
        r = '0;
        r.beat.sign = sign;
        if (!ovf && m == 0) begin
            r.flags.zero = 1'b1;
        end else if (ovf) begin
            if (e + 1 >= (1 << EW) - 1) begin
                r.beat.exponent    = '1;
                r.flags.exp_overflow = 1'b1;
            end else begin
                r.beat.mantissa = MW'((m >> 1) | (m & 1));
                r.beat.exponent = EW'(e + 1);
            end
        end else begin
            lz = MW - 1;
            for (int b = MW - 2; b >= 0; b--) begin
                if (((m >> b) & 1) == 1) begin
                    lz = MW - 2 - b;
                    break;
                end
            end
            if (e > lz) begin
                r.beat.mantissa = MW'((m << lz) & mask);
                r.beat.exponent = EW'(e - lz);
            end else begin
                sh = (e == 0) ? 0 : e - 1;
                r.beat.mantissa = MW'((m << sh) & mask);
                r.flags.underflow = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [39:0] dut_out();
        return {o_sign, o_exponent, o_mantissa, o_zero_flag, o_underflow, o_exp_overflow};
    endfunction

    exp_t        exp_q[$];
    int          n_consumed = 0;
    bit          stalled_prev = 1'b0;
    logic [39:0] out_prev = '0;

    // Scoreboard: every accepted beat is predicted, every consumed beat is checked.
    always @(negedge i_clk) begin
        if (i_rst) begin
            exp_q.delete();
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) check("stall_hold", dut_out(), out_prev);
            if (o_valid && !i_ready) check("stall_ready", o_ready, 0);
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) check("unexpected_beat", o_valid, 0);
                else check("beat", dut_out(), exp_q.pop_front());
                n_consumed++;
            end
            if (i_valid && o_ready)
                exp_q.push_back(ref_norm(i_overflow, i_sign, int'(i_exponent), longint'(i_mantissa)));
            stalled_prev = o_valid && !i_ready;
            out_prev     = dut_out();
        end
    end

    task automatic drive(input bit v, input bit ovf, input bit s, input int e, input longint m);
        i_valid    = v;
        i_overflow = ovf;
        i_sign     = s;
        i_exponent = EW'(e);
        i_mantissa = MW'(m);
    endtask

    task automatic next();
        @(posedge i_clk);
        #1;
    endtask

    task automatic gen(output bit ovf, output bit s, output int e, output longint m);
        ovf = ($urandom_range(0, 3) == 0);
        s   = 1'($urandom);
        case ($urandom_range(0, 7))
            0:       e = 0;
            1:       e = 1;
            2:       e = 254;
            3:       e = 255;
            4:       e = int'($urandom_range(0, 30));
            default: e = int'($urandom_range(0, 255));
        endcase
        if (ovf)
            m = (longint'(1) << (MW - 1)) | (longint'($urandom) & 64'h7FF_FFFF);
        else if ($urandom_range(0, 9) == 0)
            m = 0;
        else
            m = (longint'($urandom) & 64'h7FF_FFFF) >> $urandom_range(0, MW - 1);
    endtask

    task automatic directed(input string tag, input bit ovf, input int e, input longint m,
                            input longint want_m, input int want_e, input logic [2:0] want_f);
        drive(1, ovf, 1'b1, e, m);
        next();
        drive(0, ovf, 1'b1, e, m);
        check({tag, "_lat1"}, o_valid, 0);
        next();
        check({tag, "_valid"}, o_valid, 1);
        check({tag, "_mant"}, o_mantissa, want_m);
        check({tag, "_exp"}, o_exponent, want_e);
        check({tag, "_flags"}, {o_zero_flag, o_underflow, o_exp_overflow}, want_f);
        check({tag, "_sign"}, o_sign, 1);
    endtask

    initial begin
        bit     ovf, s;
        int     e;
        longint m;
        int     sent, base;

        i_rst   = 1'b1;
        i_ready = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (3) next();
        i_rst = 1'b0;
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 1);
        check("rst_outs", dut_out(), 0);

        directed("normal",   0, 100, 28'h040_0000, 28'h400_0000,  96, 3'b000);
        directed("carry",    1, 100, 28'h800_0003, 28'h400_0001, 101, 3'b000);
        directed("subnorm",  0,  10, 28'h000_0100, 28'h002_0000,   0, 3'b010);
        directed("expovf",   1, 254, 28'h800_0000, 28'h000_0000, 255, 3'b001);
        directed("zero",     0,  77, 28'h000_0000, 28'h000_0000,   0, 3'b100);
        directed("exp0",     0,   0, 28'h000_0100, 28'h000_0100,   0, 3'b010);
        directed("carry253", 1, 253, 28'h800_0000, 28'h400_0000, 254, 3'b000);
        directed("eq_lz",    0,   4, 28'h040_0000, 28'h200_0000,   0, 3'b010);
        directed("no_shift", 0,   1, 28'h400_0001, 28'h400_0001,   1, 3'b000);
        next();

        // Backpressure: five back-to-back beats, downstream stalled in cycles 3-5.
        sent = 0;
        base = n_consumed;
        for (int c = 1; c <= 20; c++) begin
            i_ready = !(c >= 3 && c <= 5);
            if (sent < 5) begin
                gen(ovf, s, e, m);
                drive(1, ovf, s, e, m);
            end else begin
                i_valid = 1'b0;
            end
            if (c == 4) check("bp_ready_low", o_ready, 0);
            @(negedge i_clk);
            if (i_valid && o_ready) sent++;
            next();
        end
        i_valid = 1'b0;
        check("bp_sent", sent, 5);
        check("bp_consumed", n_consumed - base, 5);

        // Reset with two beats in flight.
        i_ready = 1'b1;
        drive(1, 0, 0, 100, 28'h040_0000);
        next();
        drive(1, 0, 0, 50, 28'h100_0000);
        next();
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("rf_inflight", o_valid, 1);
        i_rst = 1'b1;
        next();
        i_rst = 1'b0;
        check("rf_valid", o_valid, 0);
        check("rf_outs", dut_out(), 0);
        i_ready = 1'b1;
        base = n_consumed;
        repeat (10) next();
        check("rf_no_stale", n_consumed - base, 0);

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            gen(ovf, s, e, m);
            drive($urandom_range(0, 9) < 7, ovf, s, e, m);
            i_ready = ($urandom_range(0, 9) < 7);
            next();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) next();
        check("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
